// File: rtl/a_inverse_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// a_inverse_multiplier_pkg
// Definitions shared by the matrix inversion stages: fixed-point word
// defaults, matrix dimension and the FSM state encoding of the final
// A^-1 = R^-1 * Q^H multiply stage.
// ---------------------------------------------------------------------------
package a_inverse_multiplier_pkg;

  localparam int INT_LENGTH_DEF  = 7;
  localparam int FRAC_LENGTH_DEF = 11;
  localparam int W_DEF           = INT_LENGTH_DEF + FRAC_LENGTH_DEF;

  localparam int N        = 4;
  localparam int NUM_ELEM = N * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/a_inverse_multiplier_mac.sv
// ---------------------------------------------------------------------------
// cmplx_conj_mac
// Combinational complex multiply-accumulate against a conjugated operand:
//   (a + jb) * (c - jd):  re = ac + bd,  im = bc - ad
// The products are added to the raw (unshifted) accumulator. The updated
// accumulator is also shifted down by FRAC_LENGTH (arithmetic, floor) and
// saturated to a W-bit word.
// Ports:
//   a, b         R^-1 entry real / imaginary
//   c, d         Q entry real / imaginary (conjugated here)
//   acc_re/im    current accumulator (2W+3 bits)
//   acc_re_next  accumulator including this product
//   acc_im_next
//   sat_re/im    shifted and saturated result of acc_*_next
// ---------------------------------------------------------------------------
module cmplx_conj_mac
  import a_inverse_multiplier_pkg::*;
#(
  parameter  int INT_LENGTH  = INT_LENGTH_DEF,
  parameter  int FRAC_LENGTH = FRAC_LENGTH_DEF,
  localparam int W           = INT_LENGTH + FRAC_LENGTH,
  localparam int AW          = 2 * W + 3
) (
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [W-1:0]  c,
  input  logic signed [W-1:0]  d,
  input  logic signed [AW-1:0] acc_re,
  input  logic signed [AW-1:0] acc_im,
  output logic signed [AW-1:0] acc_re_next,
  output logic signed [AW-1:0] acc_im_next,
  output logic signed [W-1:0]  sat_re,
  output logic signed [W-1:0]  sat_im
);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] ac, bd, bc, ad;
  logic signed [AW-1:0]  shift_re, shift_im;

  always_comb begin
    ac = (2*W)'(a) * (2*W)'(c);
    bd = (2*W)'(b) * (2*W)'(d);
    bc = (2*W)'(b) * (2*W)'(c);
    ad = (2*W)'(a) * (2*W)'(d);

    acc_re_next = acc_re + AW'(ac) + AW'(bd);
    acc_im_next = acc_im + AW'(bc) - AW'(ad);

    shift_re = acc_re_next >>> FRAC_LENGTH;
    shift_im = acc_im_next >>> FRAC_LENGTH;

    if (shift_re > SAT_MAX)      sat_re = SAT_MAX[W-1:0];
    else if (shift_re < SAT_MIN) sat_re = SAT_MIN[W-1:0];
    else                         sat_re = shift_re[W-1:0];

    if (shift_im > SAT_MAX)      sat_im = SAT_MAX[W-1:0];
    else if (shift_im < SAT_MIN) sat_im = SAT_MIN[W-1:0];
    else                         sat_im = shift_im[W-1:0];
  end

endmodule

// File: rtl/a_inverse_multiplier.sv
// ---------------------------------------------------------------------------
// a_inverse_multiplier
// Final stage of the 4x4 complex matrix inversion: A^-1 = R^-1 * Q^H,
//   X[i][j] = sum_{k=i..3} R^-1[i][k] * conj(Q[j][k])
// One complex MAC per cycle, 40 MAC cycles per matrix, then a one-cycle
// done pulse.
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-low reset
//   Start           one-cycle start, accepted only in IDLE
//   R_inv_re_flat   R^-1 real, row-major, (i,j) at [(4i+j)*W +: W]
//   R_inv_im_flat   R^-1 imaginary (diagonal treated as 0)
//   Q_re_flat       Q real, row-major
//   Q_im_flat       Q imaginary, row-major
//   A_inv_re_flat   result real, row-major
//   A_inv_im_flat   result imaginary, row-major
//   Busy            high during the MAC cycles
//   A_inverse_done  one-cycle pulse once all 16 results are registered
// ---------------------------------------------------------------------------
module a_inverse_multiplier
  import a_inverse_multiplier_pkg::*;
#(
  parameter  int INT_LENGTH  = INT_LENGTH_DEF,
  parameter  int FRAC_LENGTH = FRAC_LENGTH_DEF,
  localparam int W           = INT_LENGTH + FRAC_LENGTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Start,
  input  logic [NUM_ELEM*W-1:0]     R_inv_re_flat,
  input  logic [NUM_ELEM*W-1:0]     R_inv_im_flat,
  input  logic [NUM_ELEM*W-1:0]     Q_re_flat,
  input  logic [NUM_ELEM*W-1:0]     Q_im_flat,
  output logic [NUM_ELEM*W-1:0]     A_inv_re_flat,
  output logic [NUM_ELEM*W-1:0]     A_inv_im_flat,
  output logic                      Busy,
  output logic                      A_inverse_done
);

  localparam int AW = 2 * W + 3;

  state_t state, state_next;

  logic [1:0] i_idx, j_idx, k_idx;
  logic signed [AW-1:0] acc_re, acc_im, acc_re_next, acc_im_next;

  logic signed [W-1:0] r_re  [NUM_ELEM];
  logic signed [W-1:0] r_im  [NUM_ELEM];
  logic signed [W-1:0] q_re  [NUM_ELEM];
  logic signed [W-1:0] q_im  [NUM_ELEM];
  logic signed [W-1:0] res_re[NUM_ELEM];
  logic signed [W-1:0] res_im[NUM_ELEM];

  logic signed [W-1:0] op_a, op_b, op_c, op_d, sat_re, sat_im;
  logic capture, elem_last, matrix_last;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and status outputs
  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    elem_last      = 1'b0;
    matrix_last    = 1'b0;
    Busy           = 1'b0;
    A_inverse_done = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          capture    = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        Busy        = 1'b1;
        elem_last   = (k_idx == 2'd3);
        matrix_last = elem_last && (j_idx == 2'd3) && (i_idx == 2'd3);
        if (matrix_last) state_next = DONE;
      end
      DONE: begin
        A_inverse_done = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand selection: R^-1 row i, Q row j (conjugated in the MAC), column k.
  // Since k starts at i, the strictly-lower part of R^-1 is never read.
  always_comb begin
    op_a = r_re[{i_idx, k_idx}];
    op_b = (i_idx == k_idx) ? '0 : r_im[{i_idx, k_idx}];
    op_c = q_re[{j_idx, k_idx}];
    op_d = q_im[{j_idx, k_idx}];
  end

  cmplx_conj_mac #(
    .INT_LENGTH (INT_LENGTH),
    .FRAC_LENGTH(FRAC_LENGTH)
  ) u_mac (
    .a          (op_a),
    .b          (op_b),
    .c          (op_c),
    .d          (op_d),
    .acc_re     (acc_re),
    .acc_im     (acc_im),
    .acc_re_next(acc_re_next),
    .acc_im_next(acc_im_next),
    .sat_re     (sat_re),
    .sat_im     (sat_im)
  );

  // Capture registers, accumulator, index counters and result registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      i_idx  <= '0;
      j_idx  <= '0;
      k_idx  <= '0;
      acc_re <= '0;
      acc_im <= '0;
      for (int unsigned n = 0; n < NUM_ELEM; n++) begin
        r_re[n]   <= '0;
        r_im[n]   <= '0;
        q_re[n]   <= '0;
        q_im[n]   <= '0;
        res_re[n] <= '0;
        res_im[n] <= '0;
      end
    end else if (capture) begin
      i_idx  <= '0;
      j_idx  <= '0;
      k_idx  <= '0;
      acc_re <= '0;
      acc_im <= '0;
      for (int unsigned n = 0; n < NUM_ELEM; n++) begin
        r_re[n] <= R_inv_re_flat[n*W +: W];
        r_im[n] <= R_inv_im_flat[n*W +: W];
        q_re[n] <= Q_re_flat[n*W +: W];
        q_im[n] <= Q_im_flat[n*W +: W];
      end
    end else if (state == MAC) begin
      if (!elem_last) begin
        acc_re <= acc_re_next;
        acc_im <= acc_im_next;
        k_idx  <= k_idx + 2'd1;
      end else begin
        // The last product of the element goes straight into the result,
        // so the accumulator restarts from zero for the next element.
        res_re[{i_idx, j_idx}] <= sat_re;
        res_im[{i_idx, j_idx}] <= sat_im;
        acc_re <= '0;
        acc_im <= '0;
        if (j_idx != 2'd3) begin
          j_idx <= j_idx + 2'd1;
          k_idx <= i_idx;
        end else if (i_idx != 2'd3) begin
          i_idx <= i_idx + 2'd1;
          j_idx <= '0;
          k_idx <= i_idx + 2'd1;
        end else begin
          i_idx <= '0;
          j_idx <= '0;
          k_idx <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_pack
    assign A_inv_re_flat[g*W +: W] = res_re[g];
    assign A_inv_im_flat[g*W +: W] = res_im[g];
  end

endmodule

// File: tb/tb_a_inverse_multiplier.sv
// ---------------------------------------------------------------------------
// tb_a_inverse_multiplier
// Directed self-checking bench for a_inverse_multiplier (W=18, 1.0 = 2048).
// Cycle numbering: the edge that captures Start is cycle 0; after n further
// rising edges the bench is "in cycle n".
// ---------------------------------------------------------------------------
module tb_a_inverse_multiplier;
  import a_inverse_multiplier_pkg::*;

  localparam int W = W_DEF;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Start = 1'b0;
  logic [16*W-1:0] r_re_flat, r_im_flat, q_re_flat, q_im_flat;
  logic [16*W-1:0] a_re_flat, a_im_flat;
  logic Busy, done;

  logic [W-1:0] r_re[16];
  logic [W-1:0] r_im[16];
  logic [W-1:0] q_re[16];
  logic [W-1:0] q_im[16];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign r_re_flat[g*W +: W] = r_re[g];
    assign r_im_flat[g*W +: W] = r_im[g];
    assign q_re_flat[g*W +: W] = q_re[g];
    assign q_im_flat[g*W +: W] = q_im[g];
  end

  a_inverse_multiplier #(
    .INT_LENGTH (7),
    .FRAC_LENGTH(11)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Start         (Start),
    .R_inv_re_flat (r_re_flat),
    .R_inv_im_flat (r_im_flat),
    .Q_re_flat     (q_re_flat),
    .Q_im_flat     (q_im_flat),
    .A_inv_re_flat (a_re_flat),
    .A_inv_im_flat (a_im_flat),
    .Busy          (Busy),
    .A_inverse_done(done)
  );

  function automatic int out_re(input int idx);
    logic signed [W-1:0] v;
    v = a_re_flat[idx*W +: W];
    return int'(v);
  endfunction

  function automatic int out_im(input int idx);
    logic signed [W-1:0] v;
    v = a_im_flat[idx*W +: W];
    return int'(v);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_data;
    for (int n = 0; n < 16; n++) begin
      r_re[n] = '0;
      r_im[n] = '0;
      q_re[n] = '0;
      q_im[n] = '0;
    end
  endtask

  task automatic set_diag(input int r_val, input int q_val);
    for (int d = 0; d < 4; d++) begin
      r_re[5*d] = W'(r_val);
      q_re[5*d] = W'(q_val);
    end
  endtask

  // Pulses Start, then observes 60 cycles (ends in cycle 61, back in IDLE)
  task automatic run_matrix(output int first_done, output int pulses, output int busy_err);
    first_done = -1;
    pulses     = 0;
    busy_err   = 0;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (done === 1'b1) begin
        if (first_done < 0) first_done = n;
        pulses++;
      end
      if (Busy !== ((n >= 1) && (n <= 40))) busy_err++;
      tick;
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    Start = 1'b0;
    clear_data;
    tick;
    tick;
    checks++;
    if (a_re_flat !== '0) begin
      failures++;
      $display("FAIL reset_re: got %h expected 0", a_re_flat);
    end
    checks++;
    if (a_im_flat !== '0) begin
      failures++;
      $display("FAIL reset_im: got %h expected 0", a_im_flat);
    end
    checks++;
    if (Busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0 0", Busy, done);
    end
    RST = 1'b1;
    tick;
  endtask

  task automatic test_identity;
    int fd, pc, be, exp_re;
    clear_data;
    set_diag(2048, 2048);
    run_matrix(fd, pc, be);
    checks++;
    if (fd !== 41) begin
      failures++;
      $display("FAIL identity_done_cycle: got %0d expected 41", fd);
    end
    checks++;
    if (pc !== 1) begin
      failures++;
      $display("FAIL identity_done_pulses: got %0d expected 1", pc);
    end
    checks++;
    if (be !== 0) begin
      failures++;
      $display("FAIL identity_busy_profile: got %0d bad cycles expected 0", be);
    end
    for (int idx = 0; idx < 16; idx++) begin
      exp_re = (idx % 5 == 0) ? 2048 : 0;
      checks++;
      if (out_re(idx) !== exp_re) begin
        failures++;
        $display("FAIL identity_re[%0d]: got %0d expected %0d", idx, out_re(idx), exp_re);
      end
      checks++;
      if (out_im(idx) !== 0) begin
        failures++;
        $display("FAIL identity_im[%0d]: got %0d expected 0", idx, out_im(idx));
      end
    end
  endtask

  task automatic test_conjugation;
    int fd, pc, be;
    clear_data;
    r_re[0] = W'(2048);
    r_im[0] = W'(12345);   // diagonal imaginary must be ignored
    q_im[0] = W'(2048);
    run_matrix(fd, pc, be);
    checks++;
    if (out_re(0) !== 0) begin
      failures++;
      $display("FAIL conj_re00: got %0d expected 0", out_re(0));
    end
    checks++;
    if (out_im(0) !== -2048) begin
      failures++;
      $display("FAIL conj_im00: got %0d expected -2048", out_im(0));
    end
    checks++;
    if (out_re(5) !== 0) begin
      failures++;
      $display("FAIL conj_re11_overwritten: got %0d expected 0", out_re(5));
    end
  endtask

  task automatic test_saturation;
    int fd, pc, be;
    clear_data;
    for (int n = 0; n < 4; n++) r_re[n] = W'(81920);
    for (int n = 0; n < 16; n++) q_re[n] = W'(2048);
    run_matrix(fd, pc, be);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_re(j) !== 131071) begin
        failures++;
        $display("FAIL sat_pos_re[0][%0d]: got %0d expected 131071", j, out_re(j));
      end
    end
    checks++;
    if (out_im(2) !== 0 || out_re(6) !== 0) begin
      failures++;
      $display("FAIL sat_pos_other: got im02=%0d re12=%0d expected 0 0", out_im(2), out_re(6));
    end
    for (int n = 0; n < 4; n++) r_re[n] = W'(-81920);
    run_matrix(fd, pc, be);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_re(j) !== -131072) begin
        failures++;
        $display("FAIL sat_neg_re[0][%0d]: got %0d expected -131072", j, out_re(j));
      end
    end
  endtask

  task automatic test_truncation;
    int fd, pc, be;
    clear_data;
    r_re[15] = W'(1);
    q_re[15] = W'(1);
    run_matrix(fd, pc, be);
    checks++;
    if (out_re(15) !== 0) begin
      failures++;
      $display("FAIL trunc_pos_re33: got %0d expected 0", out_re(15));
    end
    r_re[15] = W'(-1);
    run_matrix(fd, pc, be);
    checks++;
    if (out_re(15) !== -1) begin
      failures++;
      $display("FAIL trunc_neg_re33: got %0d expected -1", out_re(15));
    end
    checks++;
    if (out_im(15) !== 0) begin
      failures++;
      $display("FAIL trunc_neg_im33: got %0d expected 0", out_im(15));
    end
  endtask

  task automatic test_back_to_back;
    int pulses, d0, d1, a00_41, a01_41, a33_41;
    logic busy42, busy43;
    pulses = 0; d0 = -1; d1 = -1;
    a00_41 = 0; a01_41 = 0; a33_41 = 0;
    busy42 = 1'bx; busy43 = 1'bx;
    clear_data;
    set_diag(4096, 2048);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (done === 1'b1) begin
        if (pulses == 0) d0 = n;
        else if (pulses == 1) d1 = n;
        pulses++;
      end
      if (n == 41) begin
        a00_41 = out_re(0);
        a01_41 = out_re(1);
        a33_41 = out_re(15);
      end
      if (n == 42) busy42 = Busy;
      if (n == 43) busy43 = Busy;
      if (n == 10) begin
        set_diag(2048, 2048);
        r_re[1] = W'(1024);
        Start = 1'b1;
      end else begin
        Start = (n == 41) || (n == 42);
      end
      tick;
    end
    Start = 1'b0;
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d expected 2", pulses);
    end
    checks++;
    if (d0 !== 41) begin
      failures++;
      $display("FAIL b2b_first_done: got %0d expected 41", d0);
    end
    checks++;
    if (d1 !== 83) begin
      failures++;
      $display("FAIL b2b_second_done: got %0d expected 83", d1);
    end
    checks++;
    if (a00_41 !== 4096 || a01_41 !== 0 || a33_41 !== 4096) begin
      failures++;
      $display("FAIL b2b_first_result: got %0d %0d %0d expected 4096 0 4096", a00_41, a01_41, a33_41);
    end
    checks++;
    if (busy42 !== 1'b0 || busy43 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy_restart: got %b %b expected 0 1", busy42, busy43);
    end
    checks++;
    if (out_re(0) !== 2048 || out_re(1) !== 1024 || out_re(15) !== 2048) begin
      failures++;
      $display("FAIL b2b_second_result: got %0d %0d %0d expected 2048 1024 2048", out_re(0), out_re(1), out_re(15));
    end
  endtask

  task automatic test_reset_mid;
    int fd, pc, be, stray;
    stray = 0;
    clear_data;
    set_diag(4096, 2048);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int n = 1; n < 20; n++) begin
      if (done === 1'b1) stray++;
      tick;
    end
    RST = 1'b0;
    tick;
    RST = 1'b1;
    checks++;
    if (a_re_flat !== '0 || a_im_flat !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got re=%h im=%h expected 0", a_re_flat, a_im_flat);
    end
    checks++;
    if (Busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_status: got busy=%b done=%b expected 0 0", Busy, done);
    end
    for (int n = 0; n < 50; n++) begin
      if (done === 1'b1) stray++;
      tick;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", stray);
    end
    clear_data;
    set_diag(2048, 2048);
    r_re[11] = W'(3072);
    run_matrix(fd, pc, be);
    checks++;
    if (fd !== 41) begin
      failures++;
      $display("FAIL midreset_restart_done: got %0d expected 41", fd);
    end
    checks++;
    if (out_re(0) !== 2048 || out_re(10) !== 2048 || out_re(11) !== 3072) begin
      failures++;
      $display("FAIL midreset_restart_result: got %0d %0d %0d expected 2048 2048 3072", out_re(0), out_re(10), out_re(11));
    end
  endtask

  initial begin
    clear_data;
    test_reset;
    test_identity;
    test_conjugation;
    test_saturation;
    test_truncation;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
